// File: rtl/cp0_reg.sv
// MIPS CP0 register file: Status, Cause, EPC, BadVAddr and optional Count/Compare timer.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and timer_int_o is 0.
module cp0_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  int_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_in_delay_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        int_req_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  logic wr_status, wr_cause, wr_epc;
  assign wr_status = we_i && (waddr_i == REG_STATUS);
  assign wr_cause  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc    = we_i && (waddr_i == REG_EPC);

  // Status: exception beats ERET beats MTC0 on EXL; IM/IE only see MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        im <= wdata_i[15:8];
        ie <= wdata_i[0];
      end
      if (exc_req_i)
        exl <= 1'b1;
      else if (eret_i)
        exl <= 1'b0;
      else if (wr_status)
        exl <= wdata_i[1];
    end
  end

  // Cause, EPC, BadVAddr; nested exceptions (EXL already set) keep EPC and BD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exc_code <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= {int_i[5] | timer_pend, int_i[4:0]};
      if (wr_cause)
        ip_sw <= wdata_i[9:8];
      if (exc_req_i)
        exc_code <= exc_code_i;
      if (exc_req_i && !exl) begin
        bd  <= exc_in_delay_i;
        epc <= exc_in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end else if (wr_epc) begin
        epc <= wdata_i;
      end
      if (exc_req_i && ((exc_code_i == 5'h04) || (exc_code_i == 5'h05)))
        badvaddr <= exc_badvaddr_i;
    end
  end

`ifdef CP0_TIMER_EN
  logic tick;
  logic wr_count, wr_compare;
  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);

  // Count advances on every second clock; a software write restarts the half-rate phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      compare    <= '0;
      tick       <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata_i;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick)
          count <= count + 32'd1;
      end
      if (wr_compare)
        compare <= wdata_i;
      if (wr_compare)
        timer_pend <= 1'b0;
      else if ((count == compare) && (compare != '0))
        timer_pend <= 1'b1;
    end
  end
`else
  assign count      = '0;
  assign compare    = '0;
  assign timer_pend = 1'b0;
`endif

  assign status_o    = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause_o     = {bd, 15'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
  assign epc_o       = epc;
  assign timer_int_o = timer_pend;
  assign int_req_o   = !rst && ie && !exl && (|({ip_hw, ip_sw} & im));

  always_comb begin
    data_o = '0;
    if (re_i && !rst) begin
      case (raddr_i)
        REG_BADVADDR: data_o = badvaddr;
        REG_COUNT:    data_o = count;
        REG_COMPARE:  data_o = compare;
        REG_STATUS:   data_o = status_o;
        REG_CAUSE:    data_o = cause_o;
        REG_EPC:      data_o = epc;
        default:      data_o = '0;
      endcase
    end
  end

endmodule
